ram_access_controller: RTL and testbench
========================================

# ram_access_controller

Request-sequencing master that sits directly upstream of the 32 x 32 RAM block and owns its `address`, `data_in`, `we` and `chip_select` pins. It accepts single or burst read/write commands over a valid/ready request port and drives the RAM one word per access. It returns read data and write acknowledgements over a valid/ready response port with backpressure. Bursts issue consecutive addresses, wrapping modulo RAM depth, so that datapath and loader logic never sequence the RAM directly.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, RAM address width; depth = 2^ADDR_WIDTH.
- `DATA_WIDTH`, 32, RAM word width.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  rising-edge clock, shared with the RAM.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; high only in IDLE.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_addr`  in  ADDR_WIDTH  burst start address.
- `req_len`  in  ADDR_WIDTH  burst length minus one (0 = 1 word, 31 = 32 words).
- `req_wdata`  in  DATA_WIDTH  fill word written to every address of a write burst.
- `rsp_valid`  out  1  response beat present.
- `rsp_ready`  in  1  consumer accepts beat.
- `rsp_data`  out  DATA_WIDTH  read word, or the write fill word on a write ack.
- `rsp_addr`  out  ADDR_WIDTH  address of this beat; last address written on a write ack.
- `rsp_last`  out  1  final beat of the burst.
- `ram_address`  out  ADDR_WIDTH  to RAM `address`.
- `ram_data_in`  out  DATA_WIDTH  to RAM `data_in`.
- `ram_we`  out  1  to RAM `we`.
- `ram_cs`  out  1  to RAM `chip_select`.
- `ram_data_out`  in  DATA_WIDTH  from RAM `data_out`. RAM read is combinational; RAM write commits at the rising edge when `ram_cs & ram_we`.

## Operation
- State machine states: IDLE, WRITE, READ, RESP. Internal registers: `base`, `len`, `count`, `is_write`, `wdata`.
- `ram_address` = `base + count` mod 2^ADDR_WIDTH. Wrap-around is silent: start 30, len 3 hits 30, 31, 0, 1.
- `ram_cs` = (state is WRITE or READ). `ram_we` = (state is WRITE). Both are decoded from registered state, so reset forces them low asynchronously. `ram_data_in` = `wdata`.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid & req_ready`: latch request fields, clear `count`, then go to WRITE if `req_write`, otherwise READ.
- **WRITE**
  - One RAM write per cycle.
  - If `count == len`: load the response registers (`rsp_data` = `wdata`, `rsp_addr` = current address, `rsp_last` = 1) and go to RESP.
  - Otherwise: increment `count`.
- **READ**
  - One cycle.
  - At the edge, capture `ram_data_out` into `rsp_data` and the current address into `rsp_addr`. Set `rsp_last` = (`count == len`). Go to RESP.
- **RESP**
  - `rsp_valid` = 1. Response outputs hold stable while `rsp_ready` is low.
  - On `rsp_ready`:
    - If `rsp_last`: go to IDLE.
    - Otherwise: increment `count` and go to READ.
- A write burst produces exactly one response beat, the ack. A read burst produces `len+1` beats.
- `req_valid` outside IDLE is ignored because `req_ready` = 0; no request queuing.

## Timing
- Reset values: state IDLE, `req_ready` 1, `rsp_valid` 0, `rsp_data` 0, `rsp_addr` 0, `rsp_last` 0, `ram_cs` 0, `ram_we` 0, `ram_address` 0, `ram_data_in` 0. All internal registers are 0.
- Request accepted at edge E.
- Write burst:
  - RAM writes commit at edges E+1 … E+len+1.
  - `rsp_valid` is high from E+len+1.
  - With `rsp_ready` held high, `req_ready` returns after edge E+len+2.
- Read burst:
  - Beat k is captured at edge E+1+2k and is valid from that edge.
  - With no backpressure, the burst sustains one beat every 2 cycles.
  - Each stall cycle on `rsp_ready` delays all later beats by one cycle.
- Reset mid-burst aborts immediately; `ram_we` and `ram_cs` fall without waiting for a clock edge. Words already written stay in RAM, and no response is emitted.
- Request handshake and response handshake never occur in the same cycle, because `req_ready` and `rsp_valid` are mutually exclusive.

## Test plan
- Single write then read: write addr 5, len 0, data 0xDEADBEEF, then read addr 5, len 0. Expect one ack with `rsp_addr` 5, `rsp_last` 1, then one read beat with `rsp_data` 0xDEADBEEF.
- Wrapping fill: write addr 30, len 3, data 0x12345678, then read addr 29, len 5. Expect the write ack `rsp_addr` = 1. Expect read beats at addresses 29, 30, 31, 0, 1, 2; addresses 30, 31, 0, 1 return 0x12345678, and `rsp_last` is set only on the addr-2 beat.
- Backpressure: 4-word read with `rsp_ready` low for 3 cycles on beat 1. Expect beat 1's `rsp_data`/`rsp_addr` stable throughout, no beat lost or duplicated, and `ram_cs` low while stalled.
- Busy rejection: assert `req_valid` continuously during a 32-word write burst. Expect `req_ready` 0 until the ack handshake completes and exactly one further request accepted afterwards.
- Reset mid-burst: pull `reset_n` low during cycle 3 of a len-7 write. Expect `ram_we`/`ram_cs` 0 asynchronously, `rsp_valid` 0, `req_ready` 1 after release, and only the first 2–3 addresses modified.
- Full-depth read: read addr 0, len 31. Expect 32 beats with addresses 0–31, a 64-cycle duration with `rsp_ready` high, and `rsp_last` on address 31 only.

Source files
------------

// File: rtl/ram_access_controller_if.sv
// Request/response handshake bundle for ram_access_controller.
// Master issues burst commands; slave returns read beats and write acks.
interface ram_access_controller_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] req_len;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_last;

  modport master (
    output req_valid, req_write, req_addr,
    output req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_addr, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr,
    input  req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_addr, rsp_last
  );
endinterface

// File: rtl/ram_access_controller.sv
// Burst sequencer owning the pins of a 32x32 combinational-read RAM.
// Bursts walk consecutive addresses modulo depth, one word per access.
module ram_access_controller #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  ram_access_controller_if.slave bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  output logic                  ram_cs,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);
  typedef enum logic [1:0] {
    IDLE, WRITE, READ, RESP
  } state_t;

  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] count;
  logic                  is_write;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic                  beat_last;
  logic                  last_word;

  assign last_word   = (count == len);
  assign ram_address = base + count;
  assign ram_data_in = wdata;
  assign ram_cs      = (state == WRITE) || (state == READ);
  assign ram_we      = (state == WRITE);

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_data  = beat_data;
  assign bus.rsp_addr  = beat_addr;
  assign bus.rsp_last  = beat_last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.req_valid)
          state_n = bus.req_write ? WRITE : READ;
      WRITE:
        if (last_word) state_n = RESP;
      READ:
        state_n = RESP;
      RESP:
        if (bus.rsp_ready)
          state_n = (beat_last || is_write) ? IDLE : READ;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      base      <= '0;
      len       <= '0;
      count     <= '0;
      is_write  <= 1'b0;
      wdata     <= '0;
      beat_data <= '0;
      beat_addr <= '0;
      beat_last <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (bus.req_valid) begin
            base     <= bus.req_addr;
            len      <= bus.req_len;
            wdata    <= bus.req_wdata;
            is_write <= bus.req_write;
            count    <= '0;
          end
        WRITE:
          if (last_word) begin
            beat_data <= wdata;
            beat_addr <= ram_address;
            beat_last <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        READ: begin
          beat_data <= ram_data_out;
          beat_addr <= ram_address;
          beat_last <= last_word;
        end
        RESP:
          // the next read beat starts from the following address
          if (bus.rsp_ready && !beat_last)
            count <= count + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_access_controller.sv
// Randomized bench for ram_access_controller with a RAM model
// and an expected-memory array updated from burst semantics.
module tb_ram_access_controller;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 32;

  logic          clock;
  logic          reset_n;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;
  logic          ram_we;
  logic          ram_cs;
  logic          preload;

  logic [DW-1:0] ram [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_cmp;
  int n_fail;

  ram_access_controller_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_access_controller #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_we      (ram_we),
    .ram_cs      (ram_cs),
    .ram_data_out(ram_data_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= ref_mem[i];
    end else if (ram_cs && ram_we) begin
      ram[ram_address] <= ram_data_in;
    end
  end

  assign ram_data_out = ram[ram_address];

  task automatic burst(input bit wr, input logic [AW-1:0] addr,
                       input logic [AW-1:0] len, input logic [DW-1:0] data,
                       input int stall_pct, input int stall_beat,
                       input int stall_n, input string name,
                       output int cycles);
    logic [DW-1:0] ed[$];
    logic [AW-1:0] ea[$];
    bit            el[$];
    logic [AW-1:0] a;
    int idx, wcnt, cyc, stalled, first_exp;
    bit seen;
    for (int k = 0; k <= int'(len); k++) begin
      a = addr + AW'(k);
      if (wr) ref_mem[a] = data;
      else begin
        ed.push_back(ref_mem[a]);
        ea.push_back(a);
        el.push_back(k == int'(len));
      end
    end
    if (wr) begin
      ed.push_back(data);
      ea.push_back(addr + len);
      el.push_back(1'b1);
    end
    first_exp = wr ? int'(len) + 2 : 2;
    @(negedge clock);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_idle_ready: got %b want 1", name, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = data;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = AW'($urandom);
    bus.req_len   = AW'($urandom);
    bus.req_wdata = $urandom;
    cyc = 1; idx = 0; wcnt = 0; stalled = 0; seen = 0; cycles = -1;
    while (idx < ed.size() && cyc < 3000) begin
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy_ready: got %b want 0 cyc %0d",
                 name, bus.req_ready, cyc);
      end
      if (bus.rsp_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          n_cmp++;
          if (cyc != first_exp) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d want %0d",
                     name, cyc, first_exp);
          end
        end
        n_cmp++;
        if ({bus.rsp_data, bus.rsp_addr, bus.rsp_last, ram_cs} !==
            {ed[idx], ea[idx], el[idx], 1'b0}) begin
          n_fail++;
          $display("FAIL %s_beat%0d: got d=%h a=%0d l=%b cs=%b want d=%h a=%0d l=%b cs=0",
                   name, idx, bus.rsp_data, bus.rsp_addr, bus.rsp_last,
                   ram_cs, ed[idx], ea[idx], el[idx]);
        end
        if (idx == stall_beat && stalled < stall_n) begin
          bus.rsp_ready = 1'b0;
          stalled++;
        end else begin
          bus.rsp_ready = (int'($urandom_range(99)) >= stall_pct);
        end
        if (bus.rsp_ready) begin
          idx++;
          if (idx == ed.size()) cycles = cyc;
        end
      end else begin
        a = addr + (wr ? AW'(wcnt) : AW'(idx));
        n_cmp++;
        if ({ram_cs, ram_we, ram_address, ram_data_in} !==
            {1'b1, wr, a, data}) begin
          n_fail++;
          $display("FAIL %s_ram_pins: got cs=%b we=%b a=%0d d=%h want cs=1 we=%b a=%0d d=%h",
                   name, ram_cs, ram_we, ram_address, ram_data_in,
                   wr, a, data);
        end
        if (wr) wcnt++;
        bus.rsp_ready = 1'($urandom);
      end
      @(negedge clock);
      cyc++;
    end
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if (idx != ed.size()) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats want %0d", name, idx, ed.size());
    end
    n_cmp++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s_end_idle: got valid=%b ready=%b want 0 1",
               name, bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    preload = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    repeat (2) @(negedge clock);
    preload = 1'b0;
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_last, ram_cs, ram_we} !==
        5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000",
               {bus.req_ready, bus.rsp_valid, bus.rsp_last, ram_cs, ram_we});
    end
    n_cmp++;
    if ({bus.rsp_data, bus.rsp_addr, ram_address, ram_data_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got d=%h a=%0d ra=%0d rd=%h want 0",
               bus.rsp_data, bus.rsp_addr, ram_address, ram_data_in);
    end
    reset_n = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({bus.req_ready, bus.rsp_valid, ram_cs} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 100",
               {bus.req_ready, bus.rsp_valid, ram_cs});
    end
  endtask

  task automatic test_single();
    int c;
    burst(1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 0, -1, 0, "single_wr", c);
    burst(1'b0, 5'd5, 5'd0, $urandom, 0, -1, 0, "single_rd", c);
  endtask

  task automatic test_wrap();
    int c;
    burst(1'b1, 5'd30, 5'd3, 32'h12345678, 0, -1, 0, "wrap_wr", c);
    burst(1'b0, 5'd29, 5'd5, $urandom, 0, -1, 0, "wrap_rd", c);
  endtask

  task automatic test_backpressure();
    int c;
    burst(1'b0, AW'($urandom), 5'd3, $urandom, 0, 1, 3, "bp_rd", c);
    n_cmp++;
    if (c != 11) begin
      n_fail++;
      $display("FAIL bp_duration: got %0d want 11", c);
    end
  endtask

  task automatic test_busy();
    logic [AW-1:0] a, b;
    logic [DW-1:0] d;
    int cyc;
    a = AW'($urandom);
    b = a + 5'd5;
    d = $urandom;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = d;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = 5'd31;
    bus.req_wdata = d;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.req_write = 1'b0;
    bus.req_addr  = b;
    bus.req_len   = 5'd0;
    bus.req_wdata = $urandom;
    cyc = 1;
    while (bus.rsp_valid !== 1'b1 && cyc < 100) begin
      n_cmp++;
      if (bus.req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL busy_ready: got %b want 0 cyc %0d", bus.req_ready, cyc);
      end
      @(negedge clock);
      cyc++;
    end
    n_cmp++;
    if (cyc != 33 || {bus.rsp_addr, bus.rsp_last, bus.req_ready} !==
        {a + 5'd31, 2'b10}) begin
      n_fail++;
      $display("FAIL busy_ack: got cyc=%0d a=%0d l=%b r=%b want cyc=33 a=%0d l=1 r=0",
               cyc, bus.rsp_addr, bus.rsp_last, bus.req_ready, a + 5'd31);
    end
    @(negedge clock);
    n_cmp++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_reaccept: got %b want 1", bus.req_ready);
    end
    @(negedge clock);
    bus.req_valid = 1'b0;
    n_cmp++;
    if ({bus.req_ready, ram_cs, ram_we, ram_address} !== {3'b010, b}) begin
      n_fail++;
      $display("FAIL busy_second_read: got r=%b cs=%b we=%b a=%0d want 0 1 0 %0d",
               bus.req_ready, ram_cs, ram_we, ram_address, b);
    end
    @(negedge clock);
    n_cmp++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_last} !==
        {1'b1, d, b, 1'b1}) begin
      n_fail++;
      $display("FAIL busy_second_beat: got v=%b d=%h a=%0d l=%b want 1 %h %0d 1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_addr, bus.rsp_last, d, b);
    end
    @(negedge clock);
    bus.rsp_ready = 1'b0;
    n_cmp++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_single_accept: got v=%b r=%b want 0 1",
               bus.rsp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int c;
    a = AW'($urandom);
    d = $urandom;
    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = a;
    bus.req_len   = 5'd7;
    bus.req_wdata = d;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({ram_cs, ram_we, ram_address} !== {2'b11, a + 5'd2}) begin
      n_fail++;
      $display("FAIL rst_pre: got cs=%b we=%b a=%0d want 1 1 %0d",
               ram_cs, ram_we, ram_address, a + 5'd2);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_we, ram_cs, bus.rsp_valid, bus.req_ready} !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_async: got %b want 0001",
               {ram_we, ram_cs, bus.rsp_valid, bus.req_ready});
    end
    ref_mem[a] = d;
    ref_mem[a + 5'd1] = d;
    @(negedge clock);
    reset_n = 1'b1;
    n_cmp++;
    if ({bus.rsp_data, bus.rsp_addr, bus.rsp_last, ram_address, ram_data_in}
        !== '0) begin
      n_fail++;
      $display("FAIL rst_regs: got d=%h a=%0d l=%b ra=%0d rd=%h want 0",
               bus.rsp_data, bus.rsp_addr, bus.rsp_last, ram_address,
               ram_data_in);
    end
    burst(1'b0, a, 5'd7, $urandom, 0, -1, 0, "rst_readback", c);
  endtask

  task automatic test_full_read();
    int c;
    burst(1'b0, 5'd0, 5'd31, $urandom, 0, -1, 0, "full_rd", c);
    n_cmp++;
    if (c != 64) begin
      n_fail++;
      $display("FAIL full_duration: got %0d want 64", c);
    end
  endtask

  task automatic test_random();
    int c;
    for (int i = 0; i < 24; i++) begin
      burst(1'($urandom), AW'($urandom), AW'($urandom_range(12)),
            $urandom, 30, -1, 0, "rand", c);
    end
  endtask

  task automatic test_mem_final();
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (ram[i] !== ref_mem[i]) begin
        n_fail++;
        $display("FAIL mem_word%0d: got %h want %h", i, ram[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_wrap();
    test_backpressure();
    test_busy();
    test_reset_mid();
    test_full_read();
    test_random();
    test_mem_final();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
